// File: rtl/fifo4_dmux_if.sv
// rtl/fifo4_dmux_if.sv - write/read handshake bundle for fifo4_dmux
interface fifo4_dmux_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fifo4_dmux.sv
// rtl/fifo4_dmux.sv - 4-entry FWFT FIFO whose entry loads are decoded by dmux4way
// Optional FIFO4_COUNT_EN adds the `level` occupancy output.
module dmux4way (
    input  logic       in,
    input  logic [1:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);
    assign a = in & (sel == 2'd0);
    assign b = in & (sel == 2'd1);
    assign c = in & (sel == 2'd2);
    assign d = in & (sel == 2'd3);
endmodule

module fifo4_dmux #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    fifo4_dmux_if.slave bus
`ifdef FIFO4_COUNT_EN
    ,
    output logic [2:0] level
`endif
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [4];
    logic [3:0]       load;
    logic             push, pop;

    // in_ready depends only on registered count, so there is no out_ready -> in_ready path
    assign bus.in_ready  = (count_q != 3'd4);
    assign bus.out_valid = (count_q != 3'd0);
    assign bus.out_data  = mem_q[rd_ptr_q];

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    dmux4way u_wr_dmux (
        .in  (push),
        .sel (wr_ptr_q),
        .a   (load[0]),
        .b   (load[1]),
        .c   (load[2]),
        .d   (load[3])
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    count_d = 3'd1;
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop) begin
                    count_d = count_q + 3'd1;
                    state_d = (count_q == 3'd3) ? FULL : PARTIAL;
                end else if (pop && !push) begin
                    count_d = count_q - 3'd1;
                    state_d = (count_q == 3'd1) ? EMPTY : PARTIAL;
                end
            end
            FULL: begin
                if (pop) begin
                    count_d = 3'd3;
                    state_d = PARTIAL;
                end
            end
            default: begin
                count_d = 3'd0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    mem_q[i] <= bus.in_data;
                end
            end
        end
    end

`ifdef FIFO4_COUNT_EN
    assign level = count_q;
`endif
endmodule

// File: tb/tb_fifo4_dmux.sv
// tb/tb_fifo4_dmux.sv - self-checking bench for fifo4_dmux against a queue model
module tb_fifo4_dmux;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [15:0] q[$];
    logic [15:0] data_ctr;

    fifo4_dmux_if #(.WIDTH(16)) bus ();

`ifdef FIFO4_COUNT_EN
    logic [2:0] level;
`endif

    fifo4_dmux #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FIFO4_COUNT_EN
        ,
        .level (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; the model decides push/pop from its own occupancy
    task automatic cycle(input string tag);
        bit          do_push, do_pop;
        logic [15:0] wdata;
        do_push = bus.in_valid && (q.size() < 4);
        do_pop  = bus.out_ready && (q.size() > 0);
        wdata   = bus.in_data;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(wdata);
        end
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        check({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, q.size() != 4});
        if (q.size() != 0)
            check({tag, ".out_data"}, {16'd0, bus.out_data}, {16'd0, q[0]});
`ifdef FIFO4_COUNT_EN
        check({tag, ".level"}, {29'd0, level}, q.size());
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        data_ctr = 16'h0100;

        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hFFFF;
        bus.out_ready = 1'b0;
        cycle("reset0");
        cycle("reset1");
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("reset.out_data", {16'd0, bus.out_data}, 32'h0);
        check("reset.out_valid", {31'd0, bus.out_valid}, 32'h0);
        check("reset.in_ready", {31'd0, bus.in_ready}, 32'h1);

        // fill, overflow attempt, drain
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 16'(i);
            cycle("fill");
        end
        check("full.in_ready", {31'd0, bus.in_ready}, 32'h0);
        check("full.head", {16'd0, bus.out_data}, 32'h1);
        bus.in_data = 16'h00FF;
        cycle("overflow");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain.order", {16'd0, bus.out_data}, 32'(i));
            cycle("drain");
        end
        check("drain.empty", {31'd0, bus.out_valid}, 32'h0);

        // pointer wrap
        for (int r = 0; r < 10; r++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            for (int k = 0; k < 3; k++) begin
                bus.in_data = 16'h0A00 + 16'(r * 3 + k);
                cycle("wrap.push");
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                check("wrap.order", {16'd0, bus.out_data}, {16'd0, 16'h0A00 + 16'(r * 3 + k)});
                cycle("wrap.pop");
            end
            check("wrap.empty", {31'd0, bus.out_valid}, 32'h0);
        end

        // steady push+pop at count 2
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.in_data = data_ctr; data_ctr++;
            cycle("sim.prefill");
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = data_ctr; data_ctr++;
            cycle("sim.both");
        end
        check("sim.still_valid", {31'd0, bus.out_valid}, 32'h1);
        check("sim.head", {16'd0, bus.out_data}, {16'd0, data_ctr - 16'd2});

        // full with both high: pop only
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_data = data_ctr; data_ctr++;
            cycle("sim.fill");
        end
        bus.out_ready = 1'b1;
        bus.in_data   = 16'hDEAD;
        cycle("sim.full_both");
        check("sim.full_both.in_ready", {31'd0, bus.in_ready}, 32'h1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle("sim.drain");

        // empty pass-through timing
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = 16'h1234;
        cycle("pass");
        check("pass.valid", {31'd0, bus.out_valid}, 32'h1);
        check("pass.data", {16'd0, bus.out_data}, 32'h1234);
        bus.in_valid = 1'b0;
        cycle("pass.pop");

        // reset mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 16'h5500 + 16'(k);
            cycle("rst.fill");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        cycle("rst.pulse");
        reset = 1'b0;
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'h0);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'h1);
        check("rst.out_data", {16'd0, bus.out_data}, 32'h0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        cycle("rst.push");
        bus.in_valid = 1'b0;
        check("rst.beef", {16'd0, bus.out_data}, 32'hBEEF);

        // randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = 16'($urandom);
            reset         = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
